d8_scenic_scanner: RTL



---
 rtl/d8_scenic_scanner_if.sv | 39 +++
 rtl/d8_scenic_scanner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d8_scenic_scanner_if.sv
// -----------------------------------------------------------------------------
// d8_scenic_scanner_if
// Bundles the job handshake from the dispatcher and the single registered read
// port of the shared grid memory into one connection for the scan engine.
//
// Signals:
//   job_valid / job_ready   valid/ready handshake for one tree coordinate
//   job_row, job_col        0-based tree coordinates (CNT_BITS wide)
//   job_last                marks the final job of the sweep
//   mem_rd, mem_addr        read strobe and byte address towards grid memory
//   mem_data                byte returned the cycle after mem_rd
//
// Modports:
//   master  dispatcher + memory side (drives jobs and read data)
//   slave   scan engine side (drives ready and the read request)
// -----------------------------------------------------------------------------
interface d8_scenic_scanner_if #(
  parameter int ADDR_BITS = 16,
  parameter int CNT_BITS  = 8
);
  logic                 job_valid;
  logic                 job_ready;
  logic [CNT_BITS-1:0]  job_row;
  logic [CNT_BITS-1:0]  job_col;
  logic                 job_last;
  logic                 mem_rd;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_data;

  modport master (
    output job_valid, job_row, job_col, job_last, mem_data,
    input  job_ready, mem_rd, mem_addr
  );

  modport slave (
    input  job_valid, job_row, job_col, job_last, mem_data,
    output job_ready, mem_rd, mem_addr
  );
endinterface

// File: rtl/d8_scenic_scanner.sv
// -----------------------------------------------------------------------------
// d8_scenic_scanner
// Scan engine for the Day 8 tree grid. For each accepted tree it reads the
// centre height, then walks up, right, down and left until a tree of equal or
// greater height blocks the view or the grid edge is reached. The product of
// the four viewing distances is the scenic score; a tree is visible from
// outside when any direction reaches the edge unblocked. A running maximum
// score (with coordinates) and a count of visible trees are kept across jobs.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   bus (slave)     job handshake in, grid memory read port out
//   max_score       best scenic score so far
//   max_row/max_col coordinates of max_score (earliest tree wins ties)
//   vis_count       number of visible trees so far
//   bad_job         sticky; an out-of-range job was dropped
//   done            sticky; the job flagged last has completed
//
// Grid memory is row-major ASCII with a newline after each row, so the row
// stride is GRID_W+1. Heights are compared as raw bytes.
// -----------------------------------------------------------------------------
module d8_scenic_scanner #(
  parameter int ADDR_BITS  = 16,
  parameter int GRID_W     = 99,
  parameter int GRID_H     = 99,
  parameter int SCORE_BITS = 32,
  parameter int CNT_BITS   = 8,
  parameter int VIS_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  d8_scenic_scanner_if.slave    bus,
  output logic [SCORE_BITS-1:0] max_score,
  output logic [CNT_BITS-1:0]   max_row,
  output logic [CNT_BITS-1:0]   max_col,
  output logic [VIS_BITS-1:0]   vis_count,
  output logic                  bad_job,
  output logic                  done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_C   = 3'd1;
  localparam logic [2:0] S_CAP_C  = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_CMP    = 3'd4;
  localparam logic [2:0] S_SCORE  = 3'd5;
  localparam logic [2:0] S_UPDATE = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [1:0] D_U = 2'd0;
  localparam logic [1:0] D_R = 2'd1;
  localparam logic [1:0] D_D = 2'd2;
  localparam logic [1:0] D_L = 2'd3;

  localparam logic [ADDR_BITS-1:0] STRIDE   = ADDR_BITS'(GRID_W + 1);
  localparam logic [CNT_BITS-1:0]  ROW_LAST = CNT_BITS'(GRID_H - 1);
  localparam logic [CNT_BITS-1:0]  COL_LAST = CNT_BITS'(GRID_W - 1);
  // One extra bit so a grid dimension of exactly 2**CNT_BITS still compares.
  localparam logic [CNT_BITS:0]    ROWS_X   = (CNT_BITS + 1)'(GRID_H);
  localparam logic [CNT_BITS:0]    COLS_X   = (CNT_BITS + 1)'(GRID_W);

  // Control / walk state
  logic [2:0]            r_state;
  logic [CNT_BITS-1:0]   r_crow;
  logic [CNT_BITS-1:0]   r_ccol;
  logic [ADDR_BITS-1:0]  r_caddr;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [CNT_BITS-1:0]   r_prow;
  logic [CNT_BITS-1:0]   r_pcol;
  logic [7:0]            r_centre;
  logic [1:0]            r_dir;
  logic [CNT_BITS-1:0]   r_dist [4];
  logic [3:0]            r_clear;
  logic                  r_edge;
  logic                  r_last;
  logic [SCORE_BITS-1:0] r_score;
  logic                  r_vis;

  // Accumulated results
  logic [SCORE_BITS-1:0] r_max_score;
  logic [CNT_BITS-1:0]   r_max_row;
  logic [CNT_BITS-1:0]   r_max_col;
  logic [VIS_BITS-1:0]   r_vis_count;
  logic                  r_bad;
  logic                  r_done;

  // Combinational helpers
  logic                  w_job_bad;
  logic [ADDR_BITS-1:0]  w_job_addr;
  logic                  w_ctr_edge;
  logic                  w_cell_edge;
  logic                  w_blocked;
  logic [1:0]            w_start_dir;
  logic [ADDR_BITS-1:0]  w_start_addr;
  logic [CNT_BITS-1:0]   w_start_row;
  logic [CNT_BITS-1:0]   w_start_col;
  logic [ADDR_BITS-1:0]  w_step_addr;
  logic [CNT_BITS-1:0]   w_step_row;
  logic [CNT_BITS-1:0]   w_step_col;
  logic [SCORE_BITS-1:0] w_product;

  assign bus.job_ready = (r_state == S_IDLE) && !rst;
  assign bus.mem_rd    = ((r_state == S_RD_C) || (r_state == S_ISSUE)) && !rst;
  assign bus.mem_addr  = r_addr;

  assign max_score = r_max_score;
  assign max_row   = r_max_row;
  assign max_col   = r_max_col;
  assign vis_count = r_vis_count;
  assign bad_job   = r_bad;
  assign done      = r_done;

  assign w_job_bad  = ({1'b0, bus.job_row} >= ROWS_X) || ({1'b0, bus.job_col} >= COLS_X);
  assign w_job_addr = ADDR_BITS'(bus.job_row) * STRIDE + ADDR_BITS'(bus.job_col);

  assign w_ctr_edge  = (r_crow == '0) || (r_crow == ROW_LAST) ||
                       (r_ccol == '0) || (r_ccol == COL_LAST);
  // Edge detection uses the coordinate counters, not the newline byte.
  assign w_cell_edge = (r_prow == '0) || (r_prow == ROW_LAST) ||
                       (r_pcol == '0) || (r_pcol == COL_LAST);
  assign w_blocked   = bus.mem_data >= r_centre;

  assign w_product = SCORE_BITS'(r_dist[0]) * SCORE_BITS'(r_dist[1]) *
                     SCORE_BITS'(r_dist[2]) * SCORE_BITS'(r_dist[3]);

  // First cell of a direction: up from CAP_C, otherwise the direction after
  // the current one. Always measured from the centre tree.
  always_comb begin
    w_start_dir  = (r_state == S_CAP_C) ? D_U : r_dir + 2'd1;
    w_start_addr = r_caddr;
    w_start_row  = r_crow;
    w_start_col  = r_ccol;
    case (w_start_dir)
      D_U: begin
        w_start_addr = r_caddr - STRIDE;
        w_start_row  = r_crow - CNT_BITS'(1);
      end
      D_R: begin
        w_start_addr = r_caddr + ADDR_BITS'(1);
        w_start_col  = r_ccol + CNT_BITS'(1);
      end
      D_D: begin
        w_start_addr = r_caddr + STRIDE;
        w_start_row  = r_crow + CNT_BITS'(1);
      end
      default: begin
        w_start_addr = r_caddr - ADDR_BITS'(1);
        w_start_col  = r_ccol - CNT_BITS'(1);
      end
    endcase
  end

  // Next cell further along the current direction.
  always_comb begin
    w_step_addr = r_addr;
    w_step_row  = r_prow;
    w_step_col  = r_pcol;
    case (r_dir)
      D_U: begin
        w_step_addr = r_addr - STRIDE;
        w_step_row  = r_prow - CNT_BITS'(1);
      end
      D_R: begin
        w_step_addr = r_addr + ADDR_BITS'(1);
        w_step_col  = r_pcol + CNT_BITS'(1);
      end
      D_D: begin
        w_step_addr = r_addr + STRIDE;
        w_step_row  = r_prow + CNT_BITS'(1);
      end
      default: begin
        w_step_addr = r_addr - ADDR_BITS'(1);
        w_step_col  = r_pcol - CNT_BITS'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_crow      <= '0;
      r_ccol      <= '0;
      r_caddr     <= '0;
      r_addr      <= '0;
      r_prow      <= '0;
      r_pcol      <= '0;
      r_centre    <= '0;
      r_dir       <= D_U;
      for (int unsigned i = 0; i < 4; i++) r_dist[i] <= '0;
      r_clear     <= '0;
      r_edge      <= 1'b0;
      r_last      <= 1'b0;
      r_score     <= '0;
      r_vis       <= 1'b0;
      r_max_score <= '0;
      r_max_row   <= '0;
      r_max_col   <= '0;
      r_vis_count <= '0;
      r_bad       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.job_valid) begin
            r_crow <= bus.job_row;
            r_ccol <= bus.job_col;
            r_last <= bus.job_last;
            if (w_job_bad) begin
              r_bad <= 1'b1;
              if (bus.job_last) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
              r_caddr <= w_job_addr;
              r_addr  <= w_job_addr;
              r_edge  <= 1'b0;
              r_clear <= '0;
              for (int unsigned i = 0; i < 4; i++) r_dist[i] <= '0;
              r_state <= S_RD_C;
            end
          end
        end

        S_RD_C: r_state <= S_CAP_C;

        S_CAP_C: begin
          r_centre <= bus.mem_data;
          if (w_ctr_edge) begin
            // Edge trees see out in at least one direction and score zero.
            r_edge  <= 1'b1;
            r_state <= S_SCORE;
          end else begin
            r_dir   <= w_start_dir;
            r_addr  <= w_start_addr;
            r_prow  <= w_start_row;
            r_pcol  <= w_start_col;
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: r_state <= S_CMP;

        S_CMP: begin
          r_dist[r_dir] <= r_dist[r_dir] + CNT_BITS'(1);
          if (w_blocked || w_cell_edge) begin
            if (!w_blocked) r_clear[r_dir] <= 1'b1;
            if (r_dir == D_L) begin
              r_state <= S_SCORE;
            end else begin
              r_dir   <= w_start_dir;
              r_addr  <= w_start_addr;
              r_prow  <= w_start_row;
              r_pcol  <= w_start_col;
              r_state <= S_ISSUE;
            end
          end else begin
            r_addr  <= w_step_addr;
            r_prow  <= w_step_row;
            r_pcol  <= w_step_col;
            r_state <= S_ISSUE;
          end
        end

        S_SCORE: begin
          r_score <= w_product;
          r_vis   <= r_edge || (|r_clear);
          r_state <= S_UPDATE;
        end

        S_UPDATE: begin
          // Strictly greater: the earliest tree keeps a tied maximum.
          if (r_score > r_max_score) begin
            r_max_score <= r_score;
            r_max_row   <= r_crow;
            r_max_col   <= r_ccol;
          end
          if (r_vis) r_vis_count <= r_vis_count + VIS_BITS'(1);
          if (r_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_DONE: r_state <= S_DONE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
